// File: rtl/reaction_timer_if.sv
// Purpose: button inputs and display/LED outputs of the reaction-time game controller.
// Latency: none, wires only.
// Backpressure: none; buttons are single-cycle debounced pulses, outputs are levels.
// Ports: buttonStart/buttonHit/buttonBest (to controller); ledGreen, ledRed, displayScore,
//        displayMode, newBest, busy (from controller).
interface reaction_timer_if #(
  parameter int SCORE_WIDTH = 13
);
  logic                   buttonStart;
  logic                   buttonHit;
  logic                   buttonBest;
  logic                   ledGreen;
  logic                   ledRed;
  logic [SCORE_WIDTH-1:0] displayScore;
  logic [1:0]             displayMode;
  logic                   newBest;
  logic                   busy;

  // master: button source and display consumer; slave: the controller
  modport master (
    output buttonStart, buttonHit, buttonBest,
    input  ledGreen, ledRed, displayScore, displayMode, newBest, busy
  );
  modport slave (
    input  buttonStart, buttonHit, buttonBest,
    output ledGreen, ledRed, displayScore, displayMode, newBest, busy
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Purpose: reaction-time game flow (idle/armed/go/show/foul), random go delay, tick-based score, best score.
// Latency: every output is registered and changes one clock after the triggering pulse or tick.
// Backpressure: none; button pulses are acted on in the cycle they arrive or ignored.
// Ports: clk, resetN (synchronous, active low); bus = reaction_timer_if.slave
//        (button pulses in; LEDs, display value/mode, newBest, busy out).
module reaction_timer_ctrl #(
  parameter int SCORE_WIDTH = 13,
  parameter int TICK_CYCLES = 50000,
  parameter int DELAY_MIN   = 1000,
  parameter int DELAY_MASK  = 2047,
  parameter int MAX_SCORE   = 8191
) (
  input logic            clk,
  input logic            resetN,
  reaction_timer_if.slave bus
);
  localparam int PRE_W    = $clog2(TICK_CYCLES);
  localparam int DLY_SPAN = DELAY_MIN + DELAY_MASK + 1;
  localparam int DLY_W    = (DLY_SPAN > 2) ? $clog2(DLY_SPAN) : 1;
  localparam logic [SCORE_WIDTH-1:0] BEST_NONE  = '1;
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = SCORE_WIDTH'(MAX_SCORE);
  localparam logic [SCORE_WIDTH-1:0] SCORE_LAST = SCORE_WIDTH'(MAX_SCORE - 1);

  typedef enum logic [2:0] {IDLE, ARMED, GO, SHOW, FOUL} state_t;

  state_t                 state, nextState;
  logic [15:0]            lfsr;
  logic [PRE_W-1:0]       preCnt;
  logic [DLY_W-1:0]       delayCnt, delayLoad;
  logic [SCORE_WIDTH-1:0] scoreCnt, scoreLatched, best;
  logic                   showBest, newBestFlag;
  logic                   tick, enterArmed, enterGo, takeBest;
  logic [SCORE_WIDTH-1:0] nextLatched, nextDispScore;
  logic                   nextShowBest, nextNewBest;
  logic [1:0]             nextDispMode;

  assign tick       = (preCnt == PRE_W'(TICK_CYCLES - 1));
  assign delayLoad  = DLY_W'(DELAY_MIN) + DLY_W'(lfsr & 16'(DELAY_MASK));
  // Prescaler restarts on these so the first tick lands exactly TICK_CYCLES after entry.
  assign enterArmed = (nextState == ARMED) && (state != ARMED);
  assign enterGo    = (nextState == GO) && (state != GO);

  always_comb begin
    nextState    = state;
    nextLatched  = scoreLatched;
    nextShowBest = showBest;
    nextNewBest  = newBestFlag;
    takeBest     = 1'b0;
    case (state)
      IDLE: if (bus.buttonStart) nextState = ARMED;
      ARMED: begin
        // A hit beats the final delay tick in the same cycle.
        if (bus.buttonHit)
          nextState = FOUL;
        else if (delayCnt == '0 || (tick && delayCnt == DLY_W'(1)))
          nextState = GO;
      end
      GO: begin
        // Timeout takes priority, so a simultaneous hit still latches MAX_SCORE and never sets a best.
        if (tick && scoreCnt == SCORE_LAST) begin
          nextState    = SHOW;
          nextLatched  = SCORE_MAX;
          nextShowBest = 1'b0;
          nextNewBest  = 1'b0;
        end else if (bus.buttonHit) begin
          nextState    = SHOW;
          nextLatched  = scoreCnt;
          nextShowBest = 1'b0;
          takeBest     = (scoreCnt < best);
          nextNewBest  = takeBest;
        end
      end
      SHOW: begin
        if (bus.buttonStart) begin
          nextState   = ARMED;
          nextNewBest = 1'b0;
        end else if (bus.buttonBest) begin
          nextShowBest = !showBest;
        end
      end
      FOUL: if (bus.buttonStart) nextState = ARMED;
      default: nextState = IDLE;
    endcase

    nextDispMode  = 2'b00;
    nextDispScore = '0;
    case (nextState)
      SHOW: begin
        if (!nextShowBest) begin
          nextDispMode  = 2'b01;
          nextDispScore = nextLatched;
        end else if (best != BEST_NONE) begin
          // best cannot change while in SHOW, so reading the register here is safe
          nextDispMode  = 2'b10;
          nextDispScore = best;
        end
      end
      FOUL:    nextDispMode = 2'b11;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state            <= IDLE;
      lfsr             <= 16'hACE1;
      preCnt           <= '0;
      delayCnt         <= '0;
      scoreCnt         <= '0;
      scoreLatched     <= '0;
      best             <= BEST_NONE;
      showBest         <= 1'b0;
      newBestFlag      <= 1'b0;
      bus.ledGreen     <= 1'b0;
      bus.ledRed       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.newBest      <= 1'b0;
      bus.displayMode  <= 2'b00;
      bus.displayScore <= '0;
    end else begin
      state <= nextState;
      // Fibonacci taps 16,14,13,11
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (tick || enterArmed || enterGo) preCnt <= '0;
      else                               preCnt <= preCnt + PRE_W'(1);

      if (enterArmed)
        delayCnt <= delayLoad;
      else if (state == ARMED && tick && delayCnt != '0)
        delayCnt <= delayCnt - DLY_W'(1);

      if (enterGo)                   scoreCnt <= '0;
      else if (state == GO && tick)  scoreCnt <= scoreCnt + SCORE_WIDTH'(1);

      scoreLatched <= nextLatched;
      showBest     <= nextShowBest;
      newBestFlag  <= nextNewBest;
      if (takeBest) best <= scoreCnt;

      bus.ledGreen     <= (nextState == GO);
      bus.ledRed       <= (nextState == FOUL);
      bus.busy         <= (nextState == ARMED) || (nextState == GO);
      bus.newBest      <= (nextState == SHOW) && nextNewBest;
      bus.displayMode  <= nextDispMode;
      bus.displayScore <= nextDispScore;
    end
  end
endmodule
